// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall merge, exception freeze/flush sequencing,
// stall/flush performance counters and a sticky stall watchdog.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
  parameter int          STALL_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count,
  output logic        stall_timeout
);

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] FREEZE = 2'd1;
  localparam logic [1:0] FLUSH  = 2'd2;

  localparam logic [31:0] ERET   = 32'h0000_000e;
  localparam logic [15:0] WD_LIM = 16'(STALL_TIMEOUT);

  logic [1:0]  state;
  logic [1:0]  state_nx;
  logic [31:0] target;
  logic [15:0] wd;
  logic        any_req;
  logic        exc;

  assign any_req = stallreq_if | stallreq_id
                 | stallreq_ex | stallreq_mem;
  assign exc     = excepttype_i != 32'd0;

  // Outputs are held at reset values while rst is asserted.
  always_comb begin
    stall    = 6'b000000;
    flush    = 1'b0;
    new_pc   = 32'd0;
    state_nx = RUN;
    if (!rst) begin
      unique case (state)
        RUN: begin
          if (exc) begin
            stall    = 6'b111111;
            state_nx = FREEZE;
          end else if (stallreq_mem) begin
            stall = 6'b011111;
          end else if (stallreq_ex) begin
            stall = 6'b001111;
          end else if (stallreq_id) begin
            stall = 6'b000111;
          end else if (stallreq_if) begin
            stall = 6'b000011;
          end
        end
        FREEZE: begin
          stall    = 6'b111111;
          state_nx = FLUSH;
        end
        FLUSH: begin
          flush  = 1'b1;
          new_pc = target;
        end
        default: state_nx = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      target        <= 32'd0;
      wd            <= 16'd0;
      stall_cycles  <= 32'd0;
      flush_count   <= 16'd0;
      stall_timeout <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == RUN && exc)
        target <= (excepttype_i == ERET) ? cp0_epc_i : EXC_VECTOR;
      if (stall != 6'd0 && stall_cycles != 32'hFFFF_FFFF)
        stall_cycles <= stall_cycles + 32'd1;
      if (flush)
        flush_count <= flush_count + 16'd1;
      // Counter saturates at the limit; the flag is sticky until reset.
      if (state == RUN && any_req) begin
        if (wd != WD_LIM) begin
          wd <= wd + 16'd1;
          if (wd + 16'd1 == WD_LIM)
            stall_timeout <= 1'b1;
        end
      end else begin
        wd <= 16'd0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed sequences, a vector table and random
// stimulus checked against a cycle-level behavioural model.
module tb_pipe_ctrl;

  localparam int TMO = 4;
  localparam logic [31:0] EXCV = 32'h0000_0020;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic [31:0] excepttype_i, cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;
  logic        stall_timeout;

  pipe_ctrl #(.EXC_VECTOR(EXCV), .STALL_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .excepttype_i(excepttype_i), .cp0_epc_i(cp0_epc_i),
    .stall(stall), .flush(flush), .new_pc(new_pc),
    .stall_cycles(stall_cycles), .flush_count(flush_count),
    .stall_timeout(stall_timeout)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Model: cycles remaining in the recovery sequence (2 = freeze, 1 = flush).
  int          m_left;
  logic [31:0] m_tgt;
  logic [31:0] m_sc;
  int          m_fc;
  int          m_streak;
  bit          m_tmo;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [5:0] req_mask(input logic [3:0] r);
    logic [5:0] m;
    m = 6'd0;
    for (int k = 0; k < 4; k++)
      if (r[k]) m = 6'((1 << (k + 2)) - 1);
    return m;
  endfunction

  // One cycle: drive after negedge, compare before posedge, advance model.
  // r = {mem, ex, id, if}
  task automatic cyc(input bit r_rst, input logic [3:0] r,
                     input logic [31:0] exc, input logic [31:0] epc);
    logic [5:0]  es;
    logic        ef;
    logic [31:0] ep;
    @(negedge clk);
    rst = r_rst;
    {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = r;
    excepttype_i = exc;
    cp0_epc_i = epc;
    #1;
    chk("stall_cycles", stall_cycles, m_sc);
    chk("flush_count", {16'd0, flush_count}, 32'(m_fc));
    chk("stall_timeout", {31'd0, stall_timeout}, {31'd0, m_tmo});
    es = 6'd0; ef = 1'b0; ep = 32'd0;
    if (r_rst) begin
      m_left = 0; m_tgt = 0; m_sc = 0; m_fc = 0;
      m_streak = 0; m_tmo = 0;
    end else begin
      if (m_left == 2) begin
        es = 6'h3F; m_left = 1; m_streak = 0;
      end else if (m_left == 1) begin
        ef = 1'b1; ep = m_tgt; m_left = 0; m_streak = 0;
        m_fc = (m_fc + 1) % 65536;
      end else begin
        if (exc != 0) begin
          es = 6'h3F; m_left = 2;
          m_tgt = (exc == 32'he) ? epc : EXCV;
        end else begin
          es = req_mask(r);
        end
        if (r != 0) m_streak = (m_streak < TMO) ? m_streak + 1 : TMO;
        else m_streak = 0;
        if (m_streak >= TMO) m_tmo = 1;
      end
      if (es != 0 && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
    end
    chk("stall", {26'd0, stall}, {26'd0, es});
    chk("flush", {31'd0, flush}, {31'd0, ef});
    chk("new_pc", new_pc, ep);
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [31:0] exc;
    logic [5:0]  exp_stall;
    logic        exp_flush;
  } vec_t;

  vec_t tab[$];

  initial begin
    tab = '{
      '{4'b0000, 32'h0, 6'b000000, 1'b0},
      '{4'b0001, 32'h0, 6'b000011, 1'b0},
      '{4'b0000, 32'h0, 6'b000000, 1'b0},
      '{4'b0010, 32'h0, 6'b000111, 1'b0},
      '{4'b0011, 32'h0, 6'b000111, 1'b0},
      '{4'b0000, 32'h0, 6'b000000, 1'b0},
      '{4'b0100, 32'h0, 6'b001111, 1'b0},
      '{4'b0111, 32'h0, 6'b001111, 1'b0},
      '{4'b0000, 32'h0, 6'b000000, 1'b0},
      '{4'b1000, 32'h0, 6'b011111, 1'b0},
      '{4'b1111, 32'h0, 6'b011111, 1'b0},
      '{4'b0000, 32'h0, 6'b000000, 1'b0},
      '{4'b0000, 32'h4, 6'b111111, 1'b0},
      '{4'b1111, 32'h0, 6'b111111, 1'b0},
      '{4'b1111, 32'h8, 6'b000000, 1'b1},
      '{4'b0000, 32'h0, 6'b000000, 1'b0}
    };
    m_left = 0; m_tgt = 0; m_sc = 0; m_fc = 0; m_streak = 0; m_tmo = 0;
    rst = 1'b1;
    {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = 4'b0;
    excepttype_i = 0;
    cp0_epc_i = 0;
    @(posedge clk);

    // Reset then idle
    cyc(1, 4'b0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 4'b0, 0, 0);

    // Priority
    cyc(0, 4'b0101, 0, 0);
    chk("prio_if_ex", {26'd0, stall}, 32'b001111);
    cyc(0, 4'b1101, 0, 0);
    chk("prio_mem", {26'd0, stall}, 32'b011111);
    cyc(0, 4'b0000, 0, 0);
    chk("prio_none", {26'd0, stall}, 32'd0);
    chk("stall_cycles_2", stall_cycles, 32'd2);

    // Syscall with concurrent mem stall
    cyc(0, 4'b1000, 32'h8, 0);
    chk("sys_n", {26'd0, stall}, 32'h3F);
    cyc(0, 4'b1000, 0, 0);
    chk("sys_n1_stall", {26'd0, stall}, 32'h3F);
    chk("sys_n1_flush", {31'd0, flush}, 32'd0);
    cyc(0, 4'b0000, 0, 0);
    chk("sys_n2_flush", {31'd0, flush}, 32'd1);
    chk("sys_n2_pc", new_pc, 32'h20);
    chk("sys_n2_stall", {26'd0, stall}, 32'd0);
    cyc(0, 4'b0000, 0, 0);
    chk("sys_fc", {16'd0, flush_count}, 32'd1);

    // ERET, with a second exception ignored during the sequence
    cyc(1, 4'b0, 0, 0);
    cyc(0, 4'b0, 32'he, 32'hBFC0_0100);
    cyc(0, 4'b0, 32'h8, 32'h1234);
    cyc(0, 4'b0, 32'h8, 32'h1234);
    chk("eret_flush", {31'd0, flush}, 32'd1);
    chk("eret_pc", new_pc, 32'hBFC0_0100);
    cyc(0, 4'b0, 0, 0);
    chk("eret_fc", {16'd0, flush_count}, 32'd1);
    chk("eret_no_refl", {31'd0, flush}, 32'd0);

    // Watchdog
    cyc(1, 4'b0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 4'b0010, 0, 0);
    cyc(0, 4'b0000, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 4'b0010, 0, 0);
    cyc(0, 4'b0000, 0, 0);
    chk("wd_3", {31'd0, stall_timeout}, 32'd0);
    for (int i = 0; i < 4; i++) cyc(0, 4'b0010, 0, 0);
    cyc(0, 4'b0000, 0, 0);
    chk("wd_4", {31'd0, stall_timeout}, 32'd1);
    cyc(0, 4'b0000, 0, 0);
    chk("wd_sticky", {31'd0, stall_timeout}, 32'd1);

    // Reset mid-sequence
    cyc(1, 4'b0, 0, 0);
    cyc(0, 4'b0, 32'h8, 0);
    cyc(1, 4'b0, 0, 0);
    cyc(0, 4'b0, 0, 0);
    chk("rstmid_flush", {31'd0, flush}, 32'd0);
    chk("rstmid_fc", {16'd0, flush_count}, 32'd0);
    cyc(0, 4'b0001, 0, 0);
    chk("rstmid_run", {26'd0, stall}, 32'b000011);

    // Vector table
    cyc(1, 4'b0, 0, 0);
    for (int i = 0; i < tab.size(); i++) begin
      cyc(0, tab[i].req, tab[i].exc, 32'h0000_4000);
      chk($sformatf("tab%0d_stall", i), {26'd0, stall},
          {26'd0, tab[i].exp_stall});
      chk($sformatf("tab%0d_flush", i), {31'd0, flush},
          {31'd0, tab[i].exp_flush});
    end

    // Random
    cyc(1, 4'b0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      logic [31:0] e;
      e = 0;
      if ($urandom_range(9) == 0)
        e = ($urandom_range(1) == 0) ? 32'he : 32'($urandom_range(255, 1));
      cyc(0, ($urandom_range(2) == 0) ? 4'($urandom) : 4'b0,
          e, $urandom);
    end
    cyc(0, 4'b0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
